// File: rtl/tpu_compute_seq.sv
// tpu_compute_seq: sequences memA/memB/systolic-array enables for one matmul pass per start.
// Define TPU_SEQ_PERF_EN to add the saturating pass_count output.
module tpu_compute_seq #(
    parameter int DIM  = 8,
    parameter int CNTW = $clog2(3*DIM)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic host_wr_ab,
    input  logic host_wr_c,
    output logic memA_en,
    output logic memB_en,
    output logic sa_en,
    output logic busy,
    output logic done,
    output logic conflict,
`ifdef TPU_SEQ_PERF_EN
    output logic [15:0] pass_count,
`endif
    output logic start_drop
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [CNTW-1:0] LAST = CNTW'(3*DIM-3);

    logic [1:0] state, state_nxt;
    logic [CNTW-1:0] cnt;
    logic accept, computing;

    assign computing = state == COMPUTE;
    assign accept    = start && !computing;

    always_comb begin
        state_nxt = accept ? COMPUTE :
                    computing ? ((cnt != LAST) ? COMPUTE : DONE) : IDLE;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            memA_en    <= 1'b0;
            memB_en    <= 1'b0;
            sa_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            conflict   <= 1'b0;
            start_drop <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= accept ? '0 : cnt + CNTW'(computing && cnt != LAST);
            memA_en    <= state_nxt == COMPUTE;
            memB_en    <= state_nxt == COMPUTE;
            sa_en      <= state_nxt == COMPUTE;
            busy       <= state_nxt == COMPUTE;
            done       <= state_nxt == DONE;
            conflict   <= accept ? 1'b0 : conflict | (busy & (host_wr_ab | host_wr_c));
            start_drop <= start && computing;
        end
    end

`ifdef TPU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pass_count <= '0;
        else if (done && pass_count != 16'hFFFF)
            pass_count <= pass_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tpu_compute_seq.sv
// tb_tpu_compute_seq: directed scenarios for tpu_compute_seq at DIM=8.
module tb_tpu_compute_seq;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, host_wr_ab = 1'b0, host_wr_c = 1'b0;
    logic memA_en, memB_en, sa_en, busy, done, conflict, start_drop;
`ifdef TPU_SEQ_PERF_EN
    logic [15:0] pass_count;
`endif
    logic [6:0] o;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    tpu_compute_seq #(.DIM(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .host_wr_ab(host_wr_ab), .host_wr_c(host_wr_c),
        .memA_en(memA_en), .memB_en(memB_en), .sa_en(sa_en), .busy(busy), .done(done),
        .conflict(conflict),
`ifdef TPU_SEQ_PERF_EN
        .pass_count(pass_count),
`endif
        .start_drop(start_drop)
    );

    assign o = {memA_en, memB_en, sa_en, busy, done, conflict, start_drop};

    // Expected {memA,memB,sa,busy,done} in cycle c for a pass whose start was in cycle s.
    function automatic logic [4:0] win(int c, int s);
        return (c - s >= 1 && c - s <= 22) ? 5'b11110 : (c - s == 23) ? 5'b00001 : 5'b00000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if (o !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got=%b exp=%b", c, o, 7'b0);
            end
        end
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (pass_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_pass_count got=%0d exp=0", pass_count);
        end
`endif
    endtask

    task automatic test_single_pass();
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (o[6:2] !== win(c, 0) || o[0] !== 1'b0) begin
                errors++;
                $display("FAIL single_pass c=%0d got=%b exp=%b0", c, {o[6:2], o[0]}, win(c, 0));
            end
        end
    endtask

    task automatic test_start_while_busy();
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = (c == 5);
            checks++;
            if (o[6:2] !== win(c, 0) || o[0] !== (c == 6)) begin
                errors++;
                $display("FAIL start_busy c=%0d got=%b exp=%b%b", c, {o[6:2], o[0]}, win(c, 0), c == 6);
            end
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            tick();
            start = (c == 23);
            checks++;
            if (o[6:2] !== (win(c, 0) | win(c, 23))) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, o[6:2], win(c, 0) | win(c, 23));
            end
        end
    endtask

    task automatic test_conflict();
        host_wr_c = 1'b1;
        tick();
        host_wr_c = 1'b0;
        tick();
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL idle_write_conflict got=%b exp=0", conflict);
        end
        start = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            tick();
            start = (c == 24);
            host_wr_ab = (c == 10);
            checks++;
            if (conflict !== (c >= 11 && c <= 24) || o[6:2] !== (win(c, 0) | win(c, 24))) begin
                errors++;
                $display("FAIL conflict c=%0d got=%b/%b exp=%b/%b", c, conflict, o[6:2],
                         c >= 11 && c <= 24, win(c, 0) | win(c, 24));
            end
        end
    endtask

    task automatic test_reset_mid_op();
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (pass_count !== 16'd6) begin
            errors++;
            $display("FAIL pass_count_before_reset got=%0d exp=6", pass_count);
        end
`endif
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (o[6:2] !== win(c, 0)) begin
                errors++;
                $display("FAIL pre_reset c=%0d got=%b exp=%b", c, o[6:2], win(c, 0));
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", o, 7'b0);
        end
        tick();
        tick();
        checks++;
        if (o !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold got=%b exp=%b", o, 7'b0);
        end
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (pass_count !== 16'd0) begin
            errors++;
            $display("FAIL pass_count_reset got=%0d exp=0", pass_count);
        end
`endif
        rst_n = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start = 1'b0;
            checks++;
            if (o[6:2] !== win(c, 0)) begin
                errors++;
                $display("FAIL post_reset c=%0d got=%b exp=%b", c, o[6:2], win(c, 0));
            end
        end
`ifdef TPU_SEQ_PERF_EN
        checks++;
        if (pass_count !== 16'd1) begin
            errors++;
            $display("FAIL pass_count_after got=%0d exp=1", pass_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_start_while_busy();
        test_back_to_back();
        test_conflict();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
